hyper_titan_test_ctrl: RTL
==========================

// Module: hyper_titan_test_ctrl
// PURPOSE
//  APB-mapped end-of-test controller for the hyper_titan sim/FPGA bench.
//  Replaces the fixed-delay $finish with software-driven pass/fail mailboxes (NUM_CH cores).
//  Adds a kickable watchdog and a coherent-read cycle counter.
//  Outputs are consumed by the bench top (or an FPGA LED/UART status path) to end the run.
// PARAMETERS
//  NUM_CH    4      number of exit mailboxes; range 1..16
//  DATA_W    32     APB data width
//  ADDR_W    8      APB address width; byte addressed
//  CNT_W     64     cycle counter width; DATA_W < CNT_W <= 2*DATA_W
//  WDOG_RST  1000   reset value of TIMEOUT; 0 = watchdog disabled
// PORTS
//  apb_clk_i     in   1         sole clock
//  apb_srst_i    in   1         synchronous reset, active-high
//  psel_i        in   1         APB select
//  penable_i     in   1         APB enable
//  pwrite_i      in   1         APB write
//  paddr_i       in   ADDR_W    APB address
//  pwdata_i      in   DATA_W    APB write data
//  prdata_o      out  DATA_W    APB read data
//  pready_o      out  1         tied 1 (zero wait)
//  pslverr_o     out  1         APB error
//  eot_o         out  1         end of test (PASS|FAIL|TIMEOUT)
//  pass_o        out  1         PASS state
//  timeout_o     out  1         TIMEOUT state
//  exit_code_o   out  DATA_W-1  latched exit code
//  exit_ch_o     out  max(1,$clog2(NUM_CH))  channel that ended test
//  cycle_o       out  CNT_W     live cycle counter
// BEHAVIOUR
//  Reset (sync, takes effect at the edge where apb_srst_i=1; aborts any state):
//   FSM=IDLE, all outputs 0 except pready_o=1, TIMEOUT=WDOG_RST, counters/shadow 0.
//  APB: access = psel&penable; writes commit on that edge; prdata combinational during access, else 0.
//   pslverr_o=1 (same cycle) for unmapped addr, paddr[1:0]!=0, or write to RO reg; such writes have no effect.
//  Map: 0x00 CTRL   W  bit0 start, bit1 clear (reads 0)
//       0x04 STATUS RO {eot,timeout,pass,state[2:0]} in [5:0]; state enc IDLE=0 RUN=1 PASS=2 FAIL=3 TMO=4
//       0x08 TIMEOUT RW   0x0C KICK W (any data)
//       0x10 CYC_LO RO  read latches cycle[CNT_W-1:DATA_W] into shadow
//       0x14 CYC_HI RO  returns shadow (zero-extended)
//       0x40+4*i EXIT_i RW  bit0 done, [DATA_W-1:1] code; reads last written value
//  Cycle counter: +1 every cycle from reset; saturates at all-ones; not cleared by CTRL.clear.
//  FSM:
//   IDLE -start-> RUN (wdog=0). EXIT writes in IDLE stored but do not end test.
//   RUN: wdog +1/cycle; KICK or any EXIT write resets wdog to 0 next edge.
//    EXIT_i write with bit0=1 -> PASS if code==0 else FAIL; exit_code_o<=code, exit_ch_o<=i.
//    else if TIMEOUT!=0 and wdog==TIMEOUT-1 (no kick that cycle) -> TMO;
//      exit_code_o<=all ones, exit_ch_o<=0. EXIT write beats expiry in the same cycle.
//   PASS/FAIL/TMO: terminal; start ignored; further EXIT writes stored, no state change.
//   clear (any state) -> IDLE, wdog=0, EXIT regs/exit_code_o/exit_ch_o = 0. clear&start same write: clear wins.
//  Outputs are registered from FSM state: eot_o rises 1 cycle after the ending write/expiry edge.
// TESTING
//  1 reset, read STATUS -> 0x0; read TIMEOUT -> 1000; pready_o=1 always.
//  2 start, write EXIT_2=0x1 -> next cycle eot_o=1,pass_o=1,exit_ch_o=2,exit_code_o=0.
//  3 start, TIMEOUT=10, no kicks -> eot_o&timeout_o rise exactly 11 edges after start; code=all ones.
//  4 TIMEOUT=10, KICK every 8 cycles for 100 cycles, then EXIT_0=0xB -> FAIL, exit_code_o=5.
//  5 read 0x20, write 0x04, read 0x02 -> pslverr_o=1 each, no state change.
//  6 force cycle=0x0000_0001_FFFF_FFFF: CYC_LO read, then CYC_HI after rollover -> 0x1 (shadow coherent).

Source files
------------

// File: rtl/hyper_titan_test_ctrl.sv
// hyper_titan_test_ctrl
//   APB-mapped end-of-test controller. Software ends the run by writing a
//   per-core exit mailbox (PASS when code==0, FAIL otherwise). A kickable
//   watchdog ends it with TIMEOUT. A free-running cycle counter can be read
//   coherently: reading CYC_LO snapshots the upper half for a later CYC_HI read.
// Ports
//   apb_clk_i / apb_srst_i     clock, synchronous active-high reset
//   psel_i..pwdata_i           APB requester side
//   prdata_o/pready_o/pslverr_o APB completer side (zero wait states)
//   eot_o/pass_o/timeout_o     registered status decoded from the FSM state
//   exit_code_o/exit_ch_o      code and channel that ended the test
//   cycle_o                    live saturating cycle counter
module hyper_titan_test_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int CNT_W    = 64,
  parameter int WDOG_RST = 1000,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              apb_clk_i,
  input  logic              apb_srst_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [DATA_W-1:0] pwdata_i,
  output logic [DATA_W-1:0] prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic              eot_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [DATA_W-2:0] exit_code_o,
  output logic [CH_W-1:0]   exit_ch_o,
  output logic [CNT_W-1:0]  cycle_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RUN = 3'd1, S_PASS = 3'd2, S_FAIL = 3'd3, S_TMO = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_TMO    = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_KICK   = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] A_CYC_LO = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] A_CYC_HI = ADDR_W'(8'h14);

  state_t                         r_state;
  logic                           r_eot, r_pass, r_tmo;
  logic [DATA_W-2:0]              r_code;
  logic [CH_W-1:0]                r_ch;
  logic [CNT_W-1:0]               r_cycle;
  logic [CNT_W-DATA_W-1:0]        r_shadow;
  logic [DATA_W-1:0]              r_timeout;
  logic [DATA_W-1:0]              r_wdog;
  logic [NUM_CH-1:0][DATA_W-1:0]  r_exit;

  logic              w_acc, w_wr, w_rd;
  logic              w_hit_ctrl, w_hit_stat, w_hit_tmo, w_hit_kick, w_hit_lo, w_hit_hi;
  logic              w_exit_hit;
  logic [CH_W-1:0]   w_exit_idx;
  logic              w_mapped, w_ro;
  logic              w_wr_ctrl, w_wr_tmo, w_wr_kick, w_wr_exit, w_rd_lo;
  logic [DATA_W-1:0] w_rdata;

  assign w_acc = psel_i & penable_i;
  assign w_wr  = w_acc & pwrite_i;
  assign w_rd  = w_acc & ~pwrite_i;

  // Every decoded address is word aligned, so a misaligned address simply
  // falls out as unmapped.
  assign w_hit_ctrl = (paddr_i == A_CTRL);
  assign w_hit_stat = (paddr_i == A_STATUS);
  assign w_hit_tmo  = (paddr_i == A_TMO);
  assign w_hit_kick = (paddr_i == A_KICK);
  assign w_hit_lo   = (paddr_i == A_CYC_LO);
  assign w_hit_hi   = (paddr_i == A_CYC_HI);

  always_comb begin
    w_exit_hit = 1'b0;
    w_exit_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (paddr_i == ADDR_W'(64 + 4 * i)) begin
        w_exit_hit = 1'b1;
        w_exit_idx = CH_W'(i);
      end
    end
  end

  assign w_mapped  = w_hit_ctrl | w_hit_stat | w_hit_tmo | w_hit_kick |
                     w_hit_lo | w_hit_hi | w_exit_hit;
  assign w_ro      = w_hit_stat | w_hit_lo | w_hit_hi;
  assign pslverr_o = w_acc & (~w_mapped | (pwrite_i & w_ro));
  assign pready_o  = 1'b1;

  // Write strobes only exist for writable decodes, so erroring writes are inert.
  assign w_wr_ctrl = w_wr & w_hit_ctrl;
  assign w_wr_tmo  = w_wr & w_hit_tmo;
  assign w_wr_kick = w_wr & w_hit_kick;
  assign w_wr_exit = w_wr & w_exit_hit;
  assign w_rd_lo   = w_rd & w_hit_lo;

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      if (w_hit_stat) w_rdata = DATA_W'({r_eot, r_tmo, r_pass, r_state});
      if (w_hit_tmo)  w_rdata = r_timeout;
      if (w_hit_lo)   w_rdata = r_cycle[DATA_W-1:0];
      if (w_hit_hi)   w_rdata = DATA_W'(r_shadow);
      if (w_exit_hit) w_rdata = r_exit[w_exit_idx];
    end
  end
  assign prdata_o = w_rdata;

  always_ff @(posedge apb_clk_i) begin
    if (apb_srst_i) begin
      r_state   <= S_IDLE;
      r_eot     <= 1'b0;
      r_pass    <= 1'b0;
      r_tmo     <= 1'b0;
      r_code    <= '0;
      r_ch      <= '0;
      r_cycle   <= '0;
      r_shadow  <= '0;
      r_timeout <= DATA_W'(WDOG_RST);
      r_wdog    <= '0;
      r_exit    <= '0;
    end else begin
      if (r_cycle != '1) r_cycle <= r_cycle + 1'b1;
      if (w_rd_lo)   r_shadow <= r_cycle[CNT_W-1:DATA_W];
      if (w_wr_tmo)  r_timeout <= pwdata_i;
      if (w_wr_exit) r_exit[w_exit_idx] <= pwdata_i;

      // Status lags the state by one edge.
      r_eot  <= (r_state == S_PASS) || (r_state == S_FAIL) || (r_state == S_TMO);
      r_pass <= (r_state == S_PASS);
      r_tmo  <= (r_state == S_TMO);

      if (w_wr_ctrl && pwdata_i[1]) begin
        // clear beats start in the same write
        r_state <= S_IDLE;
        r_wdog  <= '0;
        r_exit  <= '0;
        r_code  <= '0;
        r_ch    <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_wr_ctrl && pwdata_i[0]) begin
              r_state <= S_RUN;
              r_wdog  <= '0;
            end
          end
          S_RUN: begin
            // an ending EXIT write wins over watchdog expiry in the same cycle
            if (w_wr_exit && pwdata_i[0]) begin
              r_state <= (pwdata_i[DATA_W-1:1] == '0) ? S_PASS : S_FAIL;
              r_code  <= pwdata_i[DATA_W-1:1];
              r_ch    <= w_exit_idx;
            end else if (w_wr_kick || w_wr_exit) begin
              r_wdog <= '0;
            end else if ((r_timeout != '0) && (r_wdog == r_timeout - 1'b1)) begin
              r_state <= S_TMO;
              r_code  <= '1;
              r_ch    <= '0;
            end else begin
              r_wdog <= r_wdog + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign eot_o       = r_eot;
  assign pass_o      = r_pass;
  assign timeout_o   = r_tmo;
  assign exit_code_o = r_code;
  assign exit_ch_o   = r_ch;
  assign cycle_o     = r_cycle;

endmodule
